// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    PARITY
  } state_t;

  // Direction names, also used by the upstream shift register.
  localparam string DIR_RIGHT = "RIGHT";  // LSB leaves first
  localparam string DIR_LEFT  = "LEFT";   // MSB leaves first

  // Bits needed to index 0..value-1; never less than one.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/piso_if.sv
// Parallel-word handshake plus serial-line signals of the serializer.
interface piso_if #(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_last;
  logic             busy;
  logic             done;

  // Word source / line observer side.
  modport master (
    output in_valid, in_data,
    input  in_ready, ser_out, ser_valid, ser_last, busy, done
  );

  // Serializer side.
  modport slave (
    input  in_valid, in_data,
    output in_ready, ser_out, ser_valid, ser_last, busy, done
  );

endinterface

// File: rtl/piso_parity.sv
// Combinational parity of a word; odd=1 inverts the plain XOR.
module piso_parity #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic             odd,
  output logic             parity
);

  assign parity = (^data) ^ odd;

endmodule

// File: rtl/piso_serializer.sv
// Serializes one handshaken parallel word per frame, optional parity bit,
// with gapless back-to-back frames when a new word arrives on the last bit.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int    WIDTH           = 8,
  parameter string SHIFT_DIRECTION = DIR_RIGHT,
  parameter bit    PARITY_EN       = 1'b0,
  parameter bit    PARITY_ODD      = 1'b0
) (
  input logic   clk,
  input logic   rst,
  piso_if.slave bus
);

  localparam int             CW        = clog2(WIDTH);
  localparam bit             LSB_FIRST = (SHIFT_DIRECTION == DIR_RIGHT);
  localparam logic [CW-1:0]  LAST_IDX  = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  PENULT    = CW'(WIDTH - 2);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             par_q;
  logic             par_in;
  logic             ser_out_q;
  logic             ser_valid_q;
  logic             ser_last_q;
  logic             done_q;
  logic             in_ready_q;
  logic             accept;
  logic             frame_end;

  // Bit that sits at the output end of a word.
  function automatic logic out_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  // One step toward the output end, zero-filled.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? {1'b0, w[WIDTH-1:1]} : {w[WIDTH-2:0], 1'b0};
  endfunction

  piso_parity #(.WIDTH(WIDTH)) u_parity (
    .data   (bus.in_data),
    .odd    (PARITY_ODD),
    .parity (par_in)
  );

  assign accept    = bus.in_valid && in_ready_q;
  // ser_last is only ever high on the final bit of a frame in flight.
  assign frame_end = ser_last_q;

  // Frame FSM: load on handshake, shift data bits, optional parity, end or reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the data path is reset too, so ser_out reads 0 straight out of reset.
      state       <= IDLE;
      shreg       <= '0;
      cnt         <= '0;
      par_q       <= 1'b0;
      ser_out_q   <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_last_q  <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout so every branch sees pre-edge values.
      done_q <= frame_end;
      if (accept) begin
        // Reached from IDLE or from the last bit of the previous frame.
        state       <= SHIFT;
        shreg       <= bus.in_data;
        cnt         <= '0;
        par_q       <= par_in;
        ser_out_q   <= out_bit(bus.in_data);
        ser_valid_q <= 1'b1;
        ser_last_q  <= 1'b0;
        in_ready_q  <= 1'b0;
      end else if (frame_end || state == IDLE) begin
        state       <= IDLE;
        shreg       <= '0;
        cnt         <= '0;
        ser_out_q   <= 1'b0;
        ser_valid_q <= 1'b0;
        ser_last_q  <= 1'b0;
        in_ready_q  <= 1'b1;
      end else if (cnt != LAST_IDX) begin
        // SHIFT with data bits still to go.
        cnt         <= cnt + CW'(1);
        shreg       <= shift_once(shreg);
        ser_out_q   <= out_bit(shift_once(shreg));
        ser_last_q  <= (cnt == PENULT) && !PARITY_EN;
        in_ready_q  <= (cnt == PENULT) && !PARITY_EN;
      end else begin
        // Last data bit done and parity enabled: parity closes the frame.
        state       <= PARITY;
        shreg       <= shift_once(shreg);
        ser_out_q   <= par_q;
        ser_last_q  <= 1'b1;
        in_ready_q  <= 1'b1;
      end
    end
  end

  assign bus.ser_out   = ser_out_q;
  assign bus.ser_valid = ser_valid_q;
  assign bus.busy      = ser_valid_q;
  assign bus.ser_last  = ser_last_q;
  assign bus.done      = done_q;
  assign bus.in_ready  = in_ready_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench: four serializer flavours driven by one shared source.
// dut0 RIGHT/no parity, dut1 LEFT/no parity, dut2 RIGHT/even, dut3 RIGHT/odd.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       vld;
  logic [7:0] din;
  bit         chk_en;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  piso_if #(.WIDTH(8)) if0 ();
  piso_if #(.WIDTH(8)) if1 ();
  piso_if #(.WIDTH(8)) if2 ();
  piso_if #(.WIDTH(8)) if3 ();

  assign if0.in_valid = vld;  assign if0.in_data = din;
  assign if1.in_valid = vld;  assign if1.in_data = din;
  assign if2.in_valid = vld;  assign if2.in_data = din;
  assign if3.in_valid = vld;  assign if3.in_data = din;

  piso_serializer #(.WIDTH(8), .SHIFT_DIRECTION("RIGHT"), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
    u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  piso_serializer #(.WIDTH(8), .SHIFT_DIRECTION("LEFT"), .PARITY_EN(1'b0), .PARITY_ODD(1'b0))
    u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  piso_serializer #(.WIDTH(8), .SHIFT_DIRECTION("RIGHT"), .PARITY_EN(1'b1), .PARITY_ODD(1'b0))
    u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  piso_serializer #(.WIDTH(8), .SHIFT_DIRECTION("RIGHT"), .PARITY_EN(1'b1), .PARITY_ODD(1'b1))
    u_dut3 (.clk(clk), .rst(rst), .bus(if3));

  // Outputs gathered as {dut3, dut2, dut1, dut0}.
  logic [3:0] o_out, o_valid, o_last, o_busy, o_done, o_ready;
  assign o_out   = {if3.ser_out,   if2.ser_out,   if1.ser_out,   if0.ser_out};
  assign o_valid = {if3.ser_valid, if2.ser_valid, if1.ser_valid, if0.ser_valid};
  assign o_last  = {if3.ser_last,  if2.ser_last,  if1.ser_last,  if0.ser_last};
  assign o_busy  = {if3.busy,      if2.busy,      if1.busy,      if0.busy};
  assign o_done  = {if3.done,      if2.done,      if1.done,      if0.done};
  assign o_ready = {if3.in_ready,  if2.in_ready,  if1.in_ready,  if0.in_ready};

  localparam logic [3:0] CFG_LEFT = 4'b0010;
  localparam logic [3:0] CFG_PEN  = 4'b1100;
  localparam logic [3:0] CFG_ODD  = 4'b1000;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: each frame is a list of bits to emit ----
  logic [15:0] m_bits [4];   // bit 0 is the next bit on the line
  int          m_len  [4];   // bits of the current frame still to emit
  bit          m_done [4];
  bit          m_ready_ok;   // false until one clock after reset release

  function automatic logic [15:0] build_frame(input int i, input logic [7:0] d);
    logic [15:0] f;
    int ones;
    f = '0;
    ones = 0;
    for (int j = 0; j < 8; j++) begin
      f[j] = CFG_LEFT[i] ? d[7-j] : d[j];
      ones += int'(d[j]);
    end
    if (CFG_PEN[i]) f[8] = ((ones % 2) == 1) ^ CFG_ODD[i];
    return f;
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_bits[i] = '0; m_len[i] = 0; m_done[i] = 1'b0;
    end
    m_ready_ok = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        for (int i = 0; i < 4; i++) begin
          m_bits[i] = '0; m_len[i] = 0; m_done[i] = 1'b0;
        end
        m_ready_ok = 1'b0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          bit hs;
          hs = vld && m_ready_ok && (m_len[i] <= 1);
          m_done[i] = (m_len[i] == 1);
          if (m_len[i] > 0) begin
            m_bits[i] = m_bits[i] >> 1;
            m_len[i]--;
          end
          if (hs) begin
            m_bits[i] = build_frame(i, din);
            m_len[i]  = 8 + int'(CFG_PEN[i]);
          end
        end
        m_ready_ok = 1'b1;
      end
    end
  end

  // Continuous comparison of every flavour against the model, mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 4; i++) begin
          logic e_v, e_o, e_l, e_d, e_r;
          e_v = !rst && (m_len[i] > 0);
          e_o = e_v && m_bits[i][0];
          e_l = !rst && (m_len[i] == 1);
          e_d = !rst && m_done[i];
          e_r = !rst && m_ready_ok && (m_len[i] <= 1);
          check($sformatf("model d%0d ser_out", i),   16'(o_out[i]),   16'(e_o));
          check($sformatf("model d%0d ser_valid", i), 16'(o_valid[i]), 16'(e_v));
          check($sformatf("model d%0d busy", i),      16'(o_busy[i]),  16'(e_v));
          check($sformatf("model d%0d ser_last", i),  16'(o_last[i]),  16'(e_l));
          check($sformatf("model d%0d done", i),      16'(o_done[i]),  16'(e_d));
          check($sformatf("model d%0d in_ready", i),  16'(o_ready[i]), 16'(e_r));
        end
      end
    end
  end

  // ---------------- directed vectors --------------------------------------
  typedef struct {
    logic       vld;
    logic [7:0] data;
    logic [3:0] e_out, e_valid, e_last, e_done, e_ready;
  } vec_t;

  vec_t tbl [12];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [15:0] word16;
    // 8'hC1 accepted in row 0; rows are cycles, fields are {dut3,dut2,dut1,dut0}.
    tbl[0]  = '{1'b1, 8'hC1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111};
    tbl[1]  = '{1'b0, 8'h00, 4'b1111, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[2]  = '{1'b0, 8'h00, 4'b0010, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[3]  = '{1'b0, 8'h00, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[4]  = '{1'b0, 8'h00, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[5]  = '{1'b0, 8'h00, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[6]  = '{1'b0, 8'h00, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[7]  = '{1'b0, 8'h00, 4'b1101, 4'b1111, 4'b0000, 4'b0000, 4'b0000};
    tbl[8]  = '{1'b0, 8'h00, 4'b1111, 4'b1111, 4'b0011, 4'b0000, 4'b0011};
    tbl[9]  = '{1'b0, 8'h00, 4'b0100, 4'b1100, 4'b1100, 4'b0011, 4'b1111};
    tbl[10] = '{1'b0, 8'h00, 4'b0000, 4'b0000, 4'b0000, 4'b1100, 4'b1111};
    tbl[11] = '{1'b0, 8'h00, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111};

    rst = 1'b1; vld = 1'b0; din = '0; chk_en = 1'b1;

    // Reset held two cycles, then one cycle for in_ready to rise.
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    step();
    @(negedge clk);
    check("post-reset in_ready", 16'(o_ready), 16'hF);
    check("post-reset ser_valid", 16'(o_valid), 16'h0);
    step();

    // Single-frame table: all four flavours on 8'hC1.
    for (int k = 0; k < 12; k++) begin
      vld = tbl[k].vld;
      din = tbl[k].data;
      @(negedge clk);
      check($sformatf("tbl[%0d] ser_out", k),   16'(o_out),   16'(tbl[k].e_out));
      check($sformatf("tbl[%0d] ser_valid", k), 16'(o_valid), 16'(tbl[k].e_valid));
      check($sformatf("tbl[%0d] busy", k),      16'(o_busy),  16'(tbl[k].e_valid));
      check($sformatf("tbl[%0d] ser_last", k),  16'(o_last),  16'(tbl[k].e_last));
      check($sformatf("tbl[%0d] done", k),      16'(o_done),  16'(tbl[k].e_done));
      check($sformatf("tbl[%0d] in_ready", k),  16'(o_ready), 16'(tbl[k].e_ready));
      step();
    end

    // Back-to-back: C1 then 0F offered with in_valid held; dut0 must run gapless.
    word16 = 16'h0FC1;
    for (int c = 0; c < 19; c++) begin
      logic e_v, e_o;
      vld = (c <= 9);
      din = (c == 0) ? 8'hC1 : 8'h0F;
      @(negedge clk);
      e_v = (c >= 1) && (c <= 16);
      e_o = e_v && word16[(c >= 1) ? c - 1 : 0];
      check($sformatf("b2b c%0d ser_valid", c), 16'(if0.ser_valid), 16'(e_v));
      check($sformatf("b2b c%0d ser_out", c),   16'(if0.ser_out),   16'(e_o));
      check($sformatf("b2b c%0d done", c),      16'(if0.done),      16'((c == 9) || (c == 17)));
      step();
    end
    vld = 1'b0;
    repeat (4) step();

    // Abort: 8'hFF accepted, reset during the 4th bit.
    vld = 1'b1; din = 8'hFF;
    step();
    vld = 1'b0; din = 8'h00;
    repeat (3) step();
    #1;
    check("abort pre ser_valid", 16'(o_valid), 16'hF);
    rst = 1'b1;
    #1;
    check("abort ser_valid", 16'(o_valid), 16'h0);
    check("abort busy",      16'(o_busy),  16'h0);
    check("abort done",      16'(o_done),  16'h0);
    check("abort in_ready",  16'(o_ready), 16'h0);
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("abort no done c%0d", c), 16'(o_done), 16'h0);
      step();
    end
    vld = 1'b1; din = 8'h01;
    step();
    vld = 1'b0; din = 8'h00;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      check($sformatf("after-abort c%0d ser_out", c),   16'(if0.ser_out),   16'(c == 1));
      check($sformatf("after-abort c%0d ser_valid", c), 16'(if0.ser_valid), 16'(c <= 8));
      check($sformatf("after-abort c%0d done", c),      16'(if0.done),      16'(c == 9));
      step();
    end
    repeat (2) step();

    // Randomized traffic with occasional resets, judged by the model.
    for (int c = 0; c < 1500; c++) begin
      vld = ($urandom_range(0, 3) != 0);
      din = 8'($urandom);
      rst = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;
    vld = 1'b0;
    repeat (12) step();

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
